lif_array_tdm: RTL and testbench

// - Time-multiplexed array of NCH leaky integrate-and-fire neurons on one shared datapath.
// - Per channel, per time step: v <- v + ((I - v) >>> LEAK_SHIFT); spike and reset when v >= VTH.
// - Signed fixed point, FRAC fractional bits. Per-channel refractory period.
// - Input currents come from an external current memory; spikes leave as a valid/ready stream.

---
 rtl/lif_pkg.sv | 40 ++++
 rtl/lif_array_tdm_update.sv | 63 ++++++
 rtl/lif_array_tdm.sv | 134 +++++++++++++
 tb/tb_lif_array_tdm.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the time-multiplexed LIF neuron array.
// Holds the default fixed-point format, the sequencer state encoding and
// a saturating adder used by the membrane update datapath.
package lif_pkg;

    localparam int LIF_DATA_W = 32;
    localparam int LIF_FRAC   = 16;
    // 1.0 in the default Q16.16 format
    localparam logic signed [31:0] LIF_ONE = 32'sh1 <<< LIF_FRAC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CALC  = 2'd2,
        WRITE = 2'd3
    } lif_state_t;

    // Adds two values that each fit in w signed bits, then clamps the sum to
    // the w-bit signed range. Works on a 64-bit carrier, so w must be <= 62.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end else begin
            return sum;
        end
    endfunction

endpackage

// File: rtl/lif_array_tdm_update.sv
// Combinational membrane update for one neuron channel.
// Ports: v (current membrane), cur (input current), ref_cnt (refractory
// count) in; v_next, ref_next, spike out.
module lif_update
    import lif_pkg::*;
#(
    parameter int                       DATA_W     = LIF_DATA_W,
    parameter int                       LEAK_SHIFT = 3,
    parameter logic signed [DATA_W-1:0] VTH        = 32'sh0000FC93,
    parameter logic signed [DATA_W-1:0] V_RESET    = '0,
    parameter logic signed [DATA_W-1:0] V_MIN      = -LIF_ONE,
    parameter int                       REFRAC     = 0
) (
    input  logic signed [DATA_W-1:0] v,
    input  logic signed [DATA_W-1:0] cur,
    input  logic        [3:0]        ref_cnt,
    output logic signed [DATA_W-1:0] v_next,
    output logic        [3:0]        ref_next,
    output logic                     spike
);

    localparam logic signed [63:0] VTH_W  = 64'(VTH);
    localparam logic signed [63:0] VMIN_W = 64'(V_MIN);

    logic signed [63:0] v_w;
    logic signed [63:0] i_w;
    logic signed [63:0] diff;
    logic signed [63:0] d;
    logic signed [63:0] vn;

    // Leak toward the input current, saturate, clamp, then apply spike/refractory rules
    always_comb begin
        v_w      = 64'(v);
        i_w      = 64'(cur);
        diff     = i_w - v_w;
        // arithmetic shift rounds toward minus infinity
        d        = diff >>> LEAK_SHIFT;
        vn       = sat_add(v_w, d, 32'(DATA_W));
        v_next   = V_RESET;
        ref_next = 4'd0;
        spike    = 1'b0;
        if (vn < VMIN_W) begin
            vn = VMIN_W;
        end else begin
            vn = vn;
        end
        if (ref_cnt != 4'd0) begin
            // refractory: the current is ignored and the neuron is held at reset
            v_next   = V_RESET;
            ref_next = ref_cnt - 4'd1;
            spike    = 1'b0;
        end else if (vn >= VTH_W) begin
            v_next   = V_RESET;
            ref_next = 4'(REFRAC);
            spike    = 1'b1;
        end else begin
            v_next   = vn[DATA_W-1:0];
            ref_next = 4'd0;
            spike    = 1'b0;
        end
    end

endmodule

// File: rtl/lif_array_tdm.sv
// NCH leaky integrate-and-fire neurons sharing one update datapath.
// A start pulse sweeps all channels once: each channel fetches its current
// from external memory, updates, writes back, and may emit a spike event.
// Ports: clk, rst (async active-low); start/busy/done step control;
// cur_req/cur_addr/cur_data current-memory read; spk_valid/spk_ready/spk_id
// spike stream; v_valid/v_id/v_out membrane write-back report.
module lif_array_tdm
    import lif_pkg::*;
#(
    parameter int                       DATA_W     = LIF_DATA_W,
    parameter int                       FRAC       = LIF_FRAC,
    parameter int                       NCH        = 16,
    parameter int                       LEAK_SHIFT = 3,
    parameter logic signed [DATA_W-1:0] VTH        = 32'sh0000FC93,
    parameter logic signed [DATA_W-1:0] V_RESET    = '0,
    parameter logic signed [DATA_W-1:0] V_MIN      = -(DATA_W'(1) <<< FRAC),
    parameter int                       REFRAC     = 0,
    parameter int                       ID_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              cur_req,
    output logic [ID_W-1:0]   cur_addr,
    input  logic [DATA_W-1:0] cur_data,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [ID_W-1:0]   spk_id,
    output logic              v_valid,
    output logic [ID_W-1:0]   v_id,
    output logic [DATA_W-1:0] v_out
);

    localparam logic [ID_W-1:0] LAST_CH = ID_W'(NCH - 1);

    lif_state_t                state;
    logic [ID_W-1:0]           ch;
    logic signed [DATA_W-1:0]  v_mem   [NCH];
    logic        [3:0]         ref_mem [NCH];

    logic signed [DATA_W-1:0]  v_next;
    logic        [3:0]         ref_next;
    logic                      spike;

    lif_update #(
        .DATA_W    (DATA_W),
        .LEAK_SHIFT(LEAK_SHIFT),
        .VTH       (VTH),
        .V_RESET   (V_RESET),
        .V_MIN     (V_MIN),
        .REFRAC    (REFRAC)
    ) u_update (
        .v       (v_mem[ch]),
        .cur     (cur_data),
        .ref_cnt (ref_mem[ch]),
        .v_next  (v_next),
        .ref_next(ref_next),
        .spike   (spike)
    );

    // Channel sequencer, state arrays and spike handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ch        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_req   <= 1'b0;
            cur_addr  <= '0;
            spk_valid <= 1'b0;
            spk_id    <= '0;
            v_valid   <= 1'b0;
            v_id      <= '0;
            v_out     <= '0;
            for (int i = 0; i < NCH; i++) begin
                v_mem[i]   <= '0;
                ref_mem[i] <= 4'd0;
            end
        end else begin
            v_valid <= 1'b0;
            done    <= 1'b0;
            cur_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        ch       <= '0;
                        cur_req  <= 1'b1;
                        cur_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    // memory returns the current during CALC
                    state <= CALC;
                end
                CALC: begin
                    v_mem[ch]   <= v_next;
                    ref_mem[ch] <= ref_next;
                    v_out       <= v_next;
                    v_id        <= ch;
                    v_valid     <= 1'b1;
                    spk_valid   <= spike;
                    spk_id      <= ch;
                    state       <= WRITE;
                end
                WRITE: begin
                    if (spk_valid && !spk_ready) begin
                        // consumer stalled: hold the event and the sweep
                        state <= WRITE;
                    end else begin
                        spk_valid <= 1'b0;
                        if (ch == LAST_CH) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            ch       <= ch + ID_W'(1);
                            cur_addr <= ch + ID_W'(1);
                            cur_req  <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_array_tdm.sv
// Self-checking bench for lif_array_tdm. Four instances cover the default
// single channel, a four-channel array, REFRAC=2 and a full-scale threshold.
// Expected write-backs and spikes come from a bench model and are queued when
// each step is launched, then popped as the DUT reports them.
module tb_lif_array_tdm;

    typedef struct {
        int          id;
        logic [31:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  start_v;
    logic [3:0]  ready_v;
    wire  [3:0]  busy_v;
    wire  [3:0]  done_v;
    wire  [3:0]  req_v;
    wire  [3:0]  spkv_v;
    wire  [3:0]  vv_v;
    wire  [1:0]  addr_v [4];
    wire  [1:0]  sid_v  [4];
    wire  [1:0]  vid_v  [4];
    wire  [31:0] vout_v [4];
    logic [31:0] cur_mem [4][4];

    longint mv [4][4];
    int     mr [4][4];
    exp_t   exp_q [$];
    int     spk_q [$];
    int     n_cmp = 0;
    int     n_mis = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int N  = (g == 1) ? 4 : 1;
        localparam int IW = (N > 1) ? $clog2(N) : 1;
        wire  [IW-1:0] addr;
        wire  [IW-1:0] sid;
        wire  [IW-1:0] vid;
        logic [31:0]   cur;

        lif_array_tdm #(
            .NCH   (N),
            .REFRAC((g == 2) ? 2 : 0),
            .VTH   ((g == 3) ? 32'sh7FFFFFFF : 32'sh0000FC93)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .cur_req  (req_v[g]),
            .cur_addr (addr),
            .cur_data (cur),
            .spk_valid(spkv_v[g]),
            .spk_ready(ready_v[g]),
            .spk_id   (sid),
            .v_valid  (vv_v[g]),
            .v_id     (vid),
            .v_out    (vout_v[g])
        );

        assign addr_v[g] = 2'(addr);
        assign sid_v[g]  = 2'(sid);
        assign vid_v[g]  = 2'(vid);

        // current memory with one-cycle read latency
        always @(posedge clk) begin
            if (req_v[g]) cur <= cur_mem[g][addr_v[g]];
        end
    end

    function automatic int nch_of(input int k);
        return (k == 1) ? 4 : 1;
    endfunction

    function automatic longint vth_of(input int k);
        return (k == 3) ? 64'sh7FFFFFFF : 64'sh0000FC93;
    endfunction

    function automatic int refr_of(input int k);
        return (k == 2) ? 2 : 0;
    endfunction

    // reference neuron update on wide integers
    function automatic void model_upd(input longint v, input longint i, input int r,
                                      input longint vth, input int refr,
                                      output longint vo, output int ro, output bit sp);
        longint d;
        longint vn;
        sp = 1'b0;
        if (r != 0) begin
            vo = 0;
            ro = r - 1;
        end else begin
            d  = (i - v) >>> 3;
            vn = v + d;
            if (vn > 64'sd2147483647) vn = 64'sd2147483647;
            if (vn < -64'sd2147483648) vn = -64'sd2147483648;
            if (vn < -64'sd65536) vn = -64'sd65536;
            if (vn >= vth) begin
                sp = 1'b1;
                vo = 0;
                ro = refr;
            end else begin
                vo = vn;
                ro = 0;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int k, input string tag);
        check({tag, "_busy"}, busy_v[k], 0);
        check({tag, "_done"}, done_v[k], 0);
        check({tag, "_req"}, req_v[k], 0);
        check({tag, "_addr"}, addr_v[k], 0);
        check({tag, "_spkv"}, spkv_v[k], 0);
        check({tag, "_sid"}, sid_v[k], 0);
        check({tag, "_vv"}, vv_v[k], 0);
        check({tag, "_vid"}, vid_v[k], 0);
        check({tag, "_vout"}, vout_v[k], 0);
    endtask

    // Called at a negedge: queues expectations, launches a step on instance k
    // and follows it to done. hold stalls spk_ready per spike; poke fires
    // extra start pulses while busy.
    task automatic run_step(input int k, input int hold, input bit poke,
                            output int cycles, output int spikes, output logic [31:0] last_v);
        exp_t        e;
        longint      vo;
        int          ro;
        bit          sp;
        int          held;
        logic [1:0]  first_id;
        for (int c = 0; c < nch_of(k); c++) begin
            model_upd(mv[k][c], longint'($signed(cur_mem[k][c])), mr[k][c],
                      vth_of(k), refr_of(k), vo, ro, sp);
            mv[k][c] = vo;
            mr[k][c] = ro;
            e.id = c;
            e.v  = vo[31:0];
            exp_q.push_back(e);
            if (sp) spk_q.push_back(c);
        end
        spikes   = 0;
        held     = 0;
        cycles   = -1;
        last_v   = '0;
        first_id = '0;
        start_v[k] = 1'b1;
        @(posedge clk);
        for (int kk = 0; kk < 200; kk++) begin
            @(negedge clk);
            start_v[k] = poke && (kk == 2 || kk == 6);
            if (kk == 0) check("busy_after_start", busy_v[k], 1);
            if (vv_v[k]) begin
                if (exp_q.size() == 0) begin
                    check("v_unexpected", vv_v[k], 0);
                end else begin
                    e = exp_q.pop_front();
                    check("v_id", vid_v[k], e.id);
                    check("v_out", vout_v[k], e.v);
                    last_v = vout_v[k];
                end
            end
            if (spkv_v[k]) begin
                if (held > 0) check("spk_id_stable", sid_v[k], first_id);
                else first_id = sid_v[k];
                if (held < hold) begin
                    check("no_req_in_stall", req_v[k], 0);
                    ready_v[k] = 1'b0;
                    held++;
                end else begin
                    ready_v[k] = 1'b1;
                    spikes++;
                    held = 0;
                    if (spk_q.size() == 0) check("spk_unexpected", spkv_v[k], 0);
                    else check("spk_id", sid_v[k], spk_q.pop_front());
                end
            end
            if (done_v[k]) begin
                cycles = kk;
                break;
            end
        end
        if (cycles < 0) check("done_seen", done_v[k], 1);
        check("v_queue_drained", exp_q.size(), 0);
        check("spk_queue_drained", spk_q.size(), 0);
        exp_q.delete();
        spk_q.delete();
    endtask

    initial begin
        int          cyc;
        int          sp;
        int          sp_total;
        int          extra;
        logic [31:0] lv;
        logic [6:0]  mask;

        rst     = 1'b0;
        start_v = 4'b0000;
        ready_v = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                cur_mem[k][c] = 32'h0;
                mv[k][c]      = 0;
                mr[k][c]      = 0;
            end
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) check_idle_outputs(k, "reset");
        rst = 1'b1;
        @(negedge clk);

        // single channel charging toward 1.0
        cur_mem[0][0] = 32'h0001_0000;
        sp_total = 0;
        for (int s = 1; s <= 40; s++) begin
            run_step(0, 0, 1'b0, cyc, sp, lv);
            if (s == 1) check("nch1_step1_v", lv, 32'h0000_2000);
            if (s == 1) check("nch1_cycles", cyc, 3);
            if (s == 2) check("nch1_step2_v", lv, 32'h0000_3C00);
            sp_total += sp;
        end
        check("nch1_spike_count", sp_total, 1);

        // large negative drive clamps at V_MIN
        cur_mem[0][0] = 32'h8000_0000;
        for (int s = 1; s <= 6; s++) begin
            run_step(0, 0, 1'b0, cyc, sp, lv);
        end
        check("clamp_vmin", lv, 32'hFFFF_0000);

        // four channels, only channel 0 driven
        cur_mem[1][0] = 32'h0008_0000;
        run_step(1, 0, 1'b0, cyc, sp, lv);
        check("nch4_cycles", cyc, 12);
        check("nch4_spikes", sp, 1);
        check("nch4_ch3_v", lv, 32'h0);

        // spike consumer stalls for 5 cycles
        run_step(1, 5, 1'b0, cyc, sp, lv);
        check("stall_cycles", cyc, 17);
        check("stall_spikes", sp, 1);

        // starts while busy are ignored
        run_step(1, 0, 1'b1, cyc, sp, lv);
        check("poke_cycles", cyc, 12);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_v[1]) extra++;
        end
        check("poke_extra_done", extra, 0);
        check("poke_idle_busy", busy_v[1], 0);

        // refractory period of two steps
        cur_mem[2][0] = 32'h0008_0000;
        mask = '0;
        for (int s = 1; s <= 7; s++) begin
            run_step(2, 0, 1'b0, cyc, sp, lv);
            mask[s-1] = (sp != 0);
            if (s == 2) check("refrac_step2_v", lv, 32'h0);
        end
        check("refrac_spike_steps", mask, 7'b1001001);

        // near-full-scale drive with full-scale threshold
        cur_mem[3][0] = 32'h7FFF_FFFF;
        sp_total = 0;
        for (int s = 1; s <= 30; s++) begin
            run_step(3, 0, 1'b0, cyc, sp, lv);
            check("sat_sign", lv[31], 1'b0);
            sp_total += sp;
        end
        check("sat_spikes", sp_total, 0);

        // reset in the middle of a step
        cur_mem[0][0] = 32'h0001_0000;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs(0, "midreset");
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                mv[k][c] = 0;
                mr[k][c] = 0;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_v[0]) extra++;
        end
        check("midreset_no_done", extra, 0);
        run_step(0, 0, 1'b0, cyc, sp, lv);
        check("after_reset_v", lv, 32'h0000_2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
